// File: rtl/fft_sample_collector_if.sv
// Bundle between the codec receive path / FFT status and the sample collector.
// The master side drives samples and FFT status; the slave side is the collector.
interface fft_sample_collector_if #(
  parameter int SAMPLE_W = 18
);
  logic                enable;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                fft_done;

  logic [SAMPLE_W-1:0] t0;
  logic [SAMPLE_W-1:0] t1;
  logic [SAMPLE_W-1:0] t2;
  logic [SAMPLE_W-1:0] t3;
  logic [SAMPLE_W-1:0] t4;
  logic [SAMPLE_W-1:0] t5;
  logic [SAMPLE_W-1:0] t6;
  logic [SAMPLE_W-1:0] t7;
  logic [SAMPLE_W-1:0] t8;
  logic [SAMPLE_W-1:0] t9;
  logic [SAMPLE_W-1:0] t10;
  logic [SAMPLE_W-1:0] t11;
  logic [SAMPLE_W-1:0] t12;
  logic [SAMPLE_W-1:0] t13;
  logic [SAMPLE_W-1:0] t14;
  logic [SAMPLE_W-1:0] t15;
  logic                new_t;
  logic [4:0]          fill_level;
  logic [7:0]          overrun_cnt;

  modport master (
    output enable, sample_in, sample_valid, fft_done,
    input  t0, t1, t2, t3, t4, t5, t6, t7,
    input  t8, t9, t10, t11, t12, t13, t14, t15,
    input  new_t, fill_level, overrun_cnt
  );

  modport slave (
    input  enable, sample_in, sample_valid, fft_done,
    output t0, t1, t2, t3, t4, t5, t6, t7,
    output t8, t9, t10, t11, t12, t13, t14, t15,
    output new_t, fill_level, overrun_cnt
  );
endinterface

// File: rtl/fft_sample_collector.sv
// Collects a 16-sample window (optionally decimated) and hands it to the FFT
// when it reports idle; strobes arriving while the FFT is busy are counted.
module fft_sample_collector #(
  parameter int SAMPLE_W = 18,
  parameter int DECIM    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_sample_collector_if.slave bus
);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  localparam logic [4:0] DECIM_LAST        = 5'(DECIM - 1);
  localparam logic [4:0] DECIM_AFTER_FIRST = (DECIM == 1) ? 5'd0 : 5'd1;

  state_t              r_state;
  logic [4:0]          r_fill;
  logic [4:0]          r_decim;
  logic [SAMPLE_W-1:0] r_buf [16];
  logic [SAMPLE_W-1:0] r_t   [16];
  logic                r_new_t;
  logic [7:0]          r_ovr;

  logic       w_strobe;
  logic       w_take;
  logic       w_transfer;
  logic [4:0] w_decim_next;
  logic       w_buf_we;
  logic [3:0] w_buf_idx;

  assign w_strobe     = bus.enable & bus.sample_valid;
  assign w_take       = (r_decim == 5'd0);
  assign w_transfer   = (r_state == HOLD) && bus.fft_done;
  assign w_decim_next = (r_decim == DECIM_LAST) ? 5'd0 : r_decim + 5'd1;

  // A strobe landing on the transfer edge starts the next frame at slot 0.
  assign w_buf_we  = !reset && w_strobe &&
                     (((r_state == FILL) && w_take) || w_transfer);
  assign w_buf_idx = (r_state == HOLD) ? 4'd0 : r_fill[3:0];

  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[w_buf_idx] <= bus.sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
      r_fill  <= 5'd0;
      r_decim <= 5'd0;
      r_new_t <= 1'b0;
      r_ovr   <= 8'd0;
      for (int k = 0; k < 16; k++) begin
        r_t[k] <= '0;
      end
    end else begin
      r_new_t <= 1'b0;
      case (r_state)
        FILL: begin
          if (!bus.enable) begin
            r_fill  <= 5'd0;
            r_decim <= 5'd0;
          end else if (bus.sample_valid) begin
            r_decim <= w_decim_next;
            if (w_take) begin
              r_fill <= r_fill + 5'd1;
              if (r_fill == 5'd15) begin
                r_state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (bus.fft_done) begin
            r_t     <= r_buf;
            r_new_t <= 1'b1;
            r_state <= FILL;
            if (w_strobe) begin
              r_fill  <= 5'd1;
              r_decim <= DECIM_AFTER_FIRST;
            end else begin
              r_fill  <= 5'd0;
              r_decim <= 5'd0;
            end
          end else if (w_strobe && (r_ovr != 8'hFF)) begin
            r_ovr <= r_ovr + 8'd1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.new_t       = r_new_t;
  assign bus.fill_level  = r_fill;
  assign bus.overrun_cnt = r_ovr;

  assign bus.t0  = r_t[0];
  assign bus.t1  = r_t[1];
  assign bus.t2  = r_t[2];
  assign bus.t3  = r_t[3];
  assign bus.t4  = r_t[4];
  assign bus.t5  = r_t[5];
  assign bus.t6  = r_t[6];
  assign bus.t7  = r_t[7];
  assign bus.t8  = r_t[8];
  assign bus.t9  = r_t[9];
  assign bus.t10 = r_t[10];
  assign bus.t11 = r_t[11];
  assign bus.t12 = r_t[12];
  assign bus.t13 = r_t[13];
  assign bus.t14 = r_t[14];
  assign bus.t15 = r_t[15];

endmodule

// File: tb/tb_fft_sample_collector.sv
// Bench for fft_sample_collector: DECIM=1 and DECIM=4 instances share stimulus
// and are compared every cycle against a window/queue model of the collector.
module tb_fft_sample_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic [17:0] smp;
  logic        done;

  always #5 clk = ~clk;

  fft_sample_collector_if #(.SAMPLE_W(18)) if1 ();
  fft_sample_collector_if #(.SAMPLE_W(18)) if4 ();

  assign if1.enable       = en;
  assign if1.sample_in    = smp;
  assign if1.sample_valid = valid;
  assign if1.fft_done     = done;
  assign if4.enable       = en;
  assign if4.sample_in    = smp;
  assign if4.sample_valid = valid;
  assign if4.fft_done     = done;

  fft_sample_collector #(.SAMPLE_W(18), .DECIM(1)) dut1 (
    .clk  (clk),
    .reset(rst),
    .bus  (if1)
  );

  fft_sample_collector #(.SAMPLE_W(18), .DECIM(4)) dut4 (
    .clk  (clk),
    .reset(rst),
    .bus  (if4)
  );

  logic [16*18-1:0] tFlat [2];
  assign tFlat[0] = {if1.t15, if1.t14, if1.t13, if1.t12, if1.t11, if1.t10, if1.t9, if1.t8,
                     if1.t7, if1.t6, if1.t5, if1.t4, if1.t3, if1.t2, if1.t1, if1.t0};
  assign tFlat[1] = {if4.t15, if4.t14, if4.t13, if4.t12, if4.t11, if4.t10, if4.t9, if4.t8,
                     if4.t7, if4.t6, if4.t5, if4.t4, if4.t3, if4.t2, if4.t1, if4.t0};

  int vectors = 0;
  int miscompares = 0;
  int nNew [2] = '{0, 0};

  // Model: a window of captured samples, a phase counter and the last delivered frame.
  int          decimOf [2] = '{1, 4};
  int          mCnt [2];
  int          mPh  [2];
  int          mOvr [2];
  bit          mNew [2];
  logic [17:0] mBuf [2][16];
  logic [17:0] mT   [2][16];

  function automatic logic [17:0] dutT(int d, int k);
    return tFlat[d][k*18 +: 18];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void modelStep(int d, bit r, bit e, bit v, logic [17:0] s, bit fd);
    if (r) begin
      mCnt[d] = 0;
      mPh[d]  = 0;
      mOvr[d] = 0;
      mNew[d] = 0;
      for (int k = 0; k < 16; k++) mT[d][k] = '0;
      return;
    end
    mNew[d] = 0;
    if (mCnt[d] == 16) begin
      if (fd) begin
        for (int k = 0; k < 16; k++) mT[d][k] = mBuf[d][k];
        mNew[d] = 1;
        mCnt[d] = 0;
        mPh[d]  = 0;
        if (e && v) begin
          mBuf[d][0] = s;
          mCnt[d] = 1;
          mPh[d]  = 1 % decimOf[d];
        end
      end else if (e && v && mOvr[d] < 255) begin
        mOvr[d]++;
      end
    end else if (!e) begin
      mCnt[d] = 0;
      mPh[d]  = 0;
    end else if (v) begin
      if (mPh[d] == 0) begin
        mBuf[d][mCnt[d]] = s;
        mCnt[d]++;
      end
      mPh[d] = (mPh[d] + 1) % decimOf[d];
    end
  endfunction

  // Single compare process: advance the model on each edge, check 1ns later.
  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) modelStep(d, rst, en, valid, smp, done);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic       nw;
        logic [4:0] fl;
        logic [7:0] ov;
        nw = (d == 0) ? if1.new_t : if4.new_t;
        fl = (d == 0) ? if1.fill_level : if4.fill_level;
        ov = (d == 0) ? if1.overrun_cnt : if4.overrun_cnt;
        if (nw === 1'b1) nNew[d]++;
        checkOutput($sformatf("d%0d_new_t", d), {31'd0, nw}, {31'd0, mNew[d]});
        checkOutput($sformatf("d%0d_fill", d), {27'd0, fl}, mCnt[d]);
        checkOutput($sformatf("d%0d_ovr", d), {24'd0, ov}, mOvr[d]);
        for (int k = 0; k < 16; k++)
          checkOutput($sformatf("d%0d_t%0d", d, k), {14'd0, dutT(d, k)}, {14'd0, mT[d][k]});
      end
    end
  end

  task automatic applyStimulus(input logic [17:0] value, input int idle);
    valid = 1'b1;
    smp   = value;
    @(negedge clk);
    valid = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    int n0;
    rst = 1'b1; en = 1'b1; valid = 1'b0; smp = '0; done = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_fill", {27'd0, if1.fill_level}, 0);
    checkOutput("rst_ovr", {24'd0, if1.overrun_cnt}, 0);
    checkOutput("rst_new", {31'd0, if1.new_t}, 0);
    checkOutput("rst_t0", {14'd0, if1.t0}, 0);
    checkOutput("rst_t15_d4", {14'd0, if4.t15}, 0);
    rst = 1'b0;

    // Ramp 1..16 with the FFT idle
    for (int v = 1; v <= 15; v++) applyStimulus(18'(v), 2);
    valid = 1'b1; smp = 18'd16;
    @(negedge clk);
    valid = 1'b0;
    checkOutput("ramp_full", {27'd0, if1.fill_level}, 16);
    checkOutput("ramp_no_new_yet", {31'd0, if1.new_t}, 0);
    @(negedge clk);
    checkOutput("ramp_new", {31'd0, if1.new_t}, 1);
    checkOutput("ramp_t0", {14'd0, if1.t0}, 1);
    checkOutput("ramp_t7", {14'd0, if1.t7}, 8);
    checkOutput("ramp_t15", {14'd0, if1.t15}, 16);
    checkOutput("ramp_fill0", {27'd0, if1.fill_level}, 0);
    @(negedge clk);
    checkOutput("ramp_single_pulse", {31'd0, if1.new_t}, 0);

    // Busy FFT
    done = 1'b0;
    for (int v = 1; v <= 16; v++) applyStimulus(18'(v), 1);
    for (int i = 0; i < 5; i++) applyStimulus(18'd99, 1);
    checkOutput("busy_ovr", {24'd0, if1.overrun_cnt}, 5);
    checkOutput("busy_fill", {27'd0, if1.fill_level}, 16);
    checkOutput("busy_no_new", {31'd0, if1.new_t}, 0);
    done = 1'b1;
    @(negedge clk);
    checkOutput("busy_new", {31'd0, if1.new_t}, 1);
    checkOutput("busy_t0", {14'd0, if1.t0}, 1);
    checkOutput("busy_t15", {14'd0, if1.t15}, 16);

    // Decimation by 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n0 = nNew[1];
    for (int v = 0; v < 64; v++) applyStimulus(18'(v), 1);
    repeat (3) @(negedge clk);
    checkOutput("decim_pulses", nNew[1] - n0, 1);
    checkOutput("decim_t0", {14'd0, if4.t0}, 0);
    checkOutput("decim_t1", {14'd0, if4.t1}, 4);
    checkOutput("decim_t15", {14'd0, if4.t15}, 60);
    checkOutput("decim_fill", {27'd0, if4.fill_level}, 1);

    // Strobe on the transfer edge
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done = 1'b0;
    for (int v = 1; v <= 16; v++) applyStimulus(18'(v + 200), 1);
    done = 1'b1; valid = 1'b1; smp = 18'h2ABCD;
    @(negedge clk);
    valid = 1'b0;
    checkOutput("coll_fill", {27'd0, if1.fill_level}, 1);
    checkOutput("coll_new", {31'd0, if1.new_t}, 1);
    checkOutput("coll_ovr", {24'd0, if1.overrun_cnt}, 0);
    for (int v = 1; v <= 15; v++) applyStimulus(18'(v), 1);
    repeat (3) @(negedge clk);
    checkOutput("coll_t0", {14'd0, if1.t0}, 32'h2ABCD);
    checkOutput("coll_t1", {14'd0, if1.t1}, 1);
    checkOutput("coll_t15", {14'd0, if1.t15}, 15);

    // Reset mid-fill
    for (int v = 1; v <= 9; v++) applyStimulus(18'(v + 50), 1);
    checkOutput("midrst_fill9", {27'd0, if1.fill_level}, 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_t0", {14'd0, if1.t0}, 0);
    checkOutput("midrst_t15", {14'd0, if1.t15}, 0);
    checkOutput("midrst_fill", {27'd0, if1.fill_level}, 0);
    n0 = nNew[0];
    for (int v = 1; v <= 15; v++) applyStimulus(18'(v), 1);
    repeat (3) @(negedge clk);
    checkOutput("midrst_15_no_frame", nNew[0] - n0, 0);
    applyStimulus(18'd16, 3);
    checkOutput("midrst_16_frame", nNew[0] - n0, 1);

    // Enable drop mid-fill
    for (int v = 1; v <= 7; v++) applyStimulus(18'(v), 1);
    checkOutput("en_fill7", {27'd0, if1.fill_level}, 7);
    en = 1'b0;
    @(negedge clk);
    checkOutput("en_fill0", {27'd0, if1.fill_level}, 0);
    en = 1'b1;

    // Overrun saturation
    done = 1'b0;
    for (int v = 1; v <= 16; v++) applyStimulus(18'(v), 0);
    valid = 1'b1;
    repeat (300) @(negedge clk);
    valid = 1'b0;
    checkOutput("sat_ovr", {24'd0, if1.overrun_cnt}, 255);
    checkOutput("sat_fill", {27'd0, if1.fill_level}, 16);
    done = 1'b1;
    @(negedge clk);
    checkOutput("sat_new", {31'd0, if1.new_t}, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 599) == 0);
      en    = ($urandom_range(0, 9) != 0);
      valid = $urandom_range(0, 1) == 1;
      smp   = 18'($urandom);
      if ($urandom_range(0, 19) == 0) done = ~done;
      @(negedge clk);
    end
    rst = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
